// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants (shared with the ALU encoding) and control FSM state type
package cpu_pkg;

    localparam logic [2:0] OP_XOR   = 3'b000;
    localparam logic [2:0] OP_BEQ   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_ANDI  = 3'b011;
    localparam logic [2:0] OP_RLS   = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam logic [2:0] ALU_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic uses_imm(input logic [2:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_RLS);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational decode of a 9-bit instruction word
module instr_decode (
    input  logic [8:0] instr,
    output logic [2:0] alu_op,
    output logic       imm_sel,
    output logic       is_beq,
    output logic       is_load,
    output logic       is_store,
    output logic       is_halt,
    output logic [2:0] rd,
    output logic [2:0] rt
);
    import cpu_pkg::*;

    logic [2:0] op;

    assign op       = instr[8:6];
    assign rd       = instr[5:3];
    assign rt       = instr[2:0];
    assign is_beq   = (op == OP_BEQ);
    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);
    assign is_halt  = (op == OP_HALT);
    assign imm_sel  = uses_imm(op);

    // Memory and halt opcodes do not drive the ALU.
    always_comb begin
        alu_op = ALU_NONE;
        if (op <= OP_RLS) begin
            alu_op = op;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle CPU control FSM
// RETIRE_COUNT_EN: when defined, retired counts completed instructions; otherwise it is tied to 0.
module control_fsm #(
    parameter int PC_W  = 10,
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       instr,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       alu_op,
    output logic             alu_imm_sel,
    output logic [7:0]       alu_imm,
    input  logic [7:0]       alu_result,
    output logic [2:0]       reg_raddr_a,
    output logic [2:0]       reg_raddr_b,
    output logic [2:0]       reg_waddr,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             done,
    output logic [RET_W-1:0] retired
);
    import cpu_pkg::*;

    state_t          state, state_nx;
    logic [8:0]      ir;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] beq_off;
    logic            active;

    logic [2:0] dec_alu_op;
    logic       dec_imm_sel;
    logic       dec_beq, dec_load, dec_store, dec_halt;
    logic [2:0] dec_rd, dec_rt;

    instr_decode u_decode (
        .instr    (ir),
        .alu_op   (dec_alu_op),
        .imm_sel  (dec_imm_sel),
        .is_beq   (dec_beq),
        .is_load  (dec_load),
        .is_store (dec_store),
        .is_halt  (dec_halt),
        .rd       (dec_rd),
        .rt       (dec_rt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_FETCH) begin
                ir <= instr;
            end
        end
    end

    // Branch offset is the 3-bit rt field, sign-extended; pc wraps naturally.
    assign beq_off = {{(PC_W-3){dec_rt[2]}}, dec_rt};
    assign active  = (state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM)    || (state == S_WB);

    assign alu_imm     = {5'b0, dec_rt};
    assign reg_raddr_a = dec_rd;
    assign reg_raddr_b = dec_beq ? 3'd0 : dec_rt;
    assign reg_waddr   = dec_rd;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        alu_op      = ALU_NONE;
        alu_imm_sel = 1'b0;
        reg_we      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;

        if (active) begin
            alu_op      = dec_alu_op;
            alu_imm_sel = dec_imm_sel;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                end
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: state_nx = dec_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (dec_beq) begin
                    state_nx = S_FETCH;
                    pc_nx    = (alu_result == 8'd0) ? pc + beq_off : pc + PC_W'(1);
                end else if (dec_load || dec_store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_store;
                if (mem_ack) begin
                    if (dec_store) begin
                        state_nx = S_FETCH;
                        pc_nx    = pc + PC_W'(1);
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                state_nx = S_FETCH;
                pc_nx    = pc + PC_W'(1);
            end
            S_HALT: begin
                done = 1'b1;
                if (start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef RETIRE_COUNT_EN
    logic             retire;
    logic [RET_W-1:0] ret_q;

    // An instruction completes on the cycle it leaves its last state.
    assign retire = ((state == S_DECODE) && dec_halt) ||
                    ((state == S_EXEC) && dec_beq) ||
                    ((state == S_MEM) && mem_ack && dec_store) ||
                    (state == S_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            ret_q <= '0;
        end else if (retire) begin
            ret_q <= ret_q + RET_W'(1);
        end
    end

    assign retired = ret_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - self-checking bench for control_fsm with an instruction-level trace model
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset, start, mem_ack;
    logic [8:0]  instr;
    logic [9:0]  pc;
    logic [2:0]  alu_op;
    logic        alu_imm_sel;
    logic [7:0]  alu_imm;
    logic [7:0]  alu_result;
    logic [2:0]  reg_raddr_a, reg_raddr_b, reg_waddr;
    logic        reg_we, mem_req, mem_we, done;
    logic [15:0] retired;

    logic [8:0] rom     [0:1023];
    logic [7:0] alu_tbl [0:1023];
    int         ack_dly [0:1023];

    int checks = 0;
    int failures = 0;
    int model_ret = 0;

    typedef struct {
        logic [9:0]  pc;
        logic [2:0]  op;
        logic        isel;
        logic        dec;
        logic [2:0]  ra, rb;
        logic [7:0]  imm;
        logic        we;
        logic [2:0]  wa;
        logic        mreq, mwe, done;
        logic [15:0] ret;
        logic        ack, start;
    } rec_t;

    rec_t exp_q[$];

    control_fsm #(.PC_W(10), .RET_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
        .alu_op(alu_op), .alu_imm_sel(alu_imm_sel), .alu_imm(alu_imm),
        .alu_result(alu_result), .reg_raddr_a(reg_raddr_a), .reg_raddr_b(reg_raddr_b),
        .reg_waddr(reg_waddr), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .done(done), .retired(retired)
    );

    always #5 clk = ~clk;

    assign instr      = rom[pc];
    assign alu_result = alu_tbl[pc];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_ret();
`ifdef RETIRE_COUNT_EN
        return model_ret[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic push(input rec_t r);
        rec_t t;
        t = r;
        t.ret = exp_ret();
        exp_q.push_back(t);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) begin
            rom[i]     = 9'b111_000_000;
            alu_tbl[i] = 8'd0;
            ack_dly[i] = 0;
        end
    endtask

    // Expected per-cycle outputs, derived instruction by instruction from pc 0 until a halt.
    task automatic build_trace(input int halt_cycles);
        logic [9:0] p;
        logic [2:0] op, rd, rt;
        rec_t r;
        exp_q.delete();
        p = 10'd0;
        for (int guard = 0; guard < 64; guard++) begin
            op = rom[p][8:6];
            rd = rom[p][5:3];
            rt = rom[p][2:0];
            r = '{default: '0};
            r.pc = p; r.op = 3'b111; r.ack = 1'b1;
            push(r);
            r.ack = 1'b0; r.dec = 1'b1;
            r.op = (op <= 3'd4) ? op : 3'b111;
            r.isel = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
            r.ra = rd; r.rb = (op == 3'd1) ? 3'd0 : rt; r.imm = {5'b0, rt};
            push(r);
            if (op == 3'd7) begin
                model_ret++;
                r = '{default: '0};
                r.pc = p; r.op = 3'b111; r.done = 1'b1;
                for (int k = 0; k < halt_cycles; k++) push(r);
                return;
            end
            r.dec = 1'b0; r.start = 1'b1;
            push(r);
            r.start = 1'b0;
            if (op == 3'd1) begin
                model_ret++;
                p = (alu_tbl[p] == 8'd0) ? p + {{7{rt[2]}}, rt} : p + 10'd1;
                continue;
            end
            if (op == 3'd5 || op == 3'd6) begin
                for (int k = 0; k <= ack_dly[p]; k++) begin
                    r.mreq = 1'b1; r.mwe = (op == 3'd6); r.ack = (k == ack_dly[p]);
                    push(r);
                end
                r.mreq = 1'b0; r.mwe = 1'b0;
                if (op == 3'd6) begin
                    model_ret++;
                    p = p + 10'd1;
                    continue;
                end
            end
            r.we = 1'b1; r.wa = rd; r.ack = 1'b1;
            push(r);
            model_ret++;
            p = p + 10'd1;
        end
    endtask

    task automatic run_trace(output int first_we, output int n_req, output int n_we);
        rec_t r;
        first_we = -1; n_req = 0; n_we = 0;
        foreach (exp_q[i]) begin
            r = exp_q[i];
            start = r.start;
            mem_ack = r.ack;
            @(negedge clk);
            chk($sformatf("c%0d_pc", i), pc, r.pc);
            chk($sformatf("c%0d_alu_op", i), alu_op, r.op);
            chk($sformatf("c%0d_imm_sel", i), alu_imm_sel, r.isel);
            chk($sformatf("c%0d_reg_we", i), reg_we, r.we);
            chk($sformatf("c%0d_mem_req", i), mem_req, r.mreq);
            chk($sformatf("c%0d_mem_we", i), mem_we, r.mwe);
            chk($sformatf("c%0d_done", i), done, r.done);
            chk($sformatf("c%0d_retired", i), retired, r.ret);
            if (r.dec) begin
                chk($sformatf("c%0d_raddr_a", i), reg_raddr_a, r.ra);
                chk($sformatf("c%0d_raddr_b", i), reg_raddr_b, r.rb);
                chk($sformatf("c%0d_alu_imm", i), alu_imm, r.imm);
            end
            if (r.we) chk($sformatf("c%0d_waddr", i), reg_waddr, r.wa);
            if (reg_we && first_we < 0) first_we = i + 1;
            if (mem_req) n_req++;
            if (reg_we) n_we++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic reset_start();
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        model_ret = 0;
        chk("rst_pc", pc, 0);
        chk("rst_alu_op", alu_op, 3'b111);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_retired", retired, 0);
        reset = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int fw, nr, nw;
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        clear_prog();
        repeat (2) @(posedge clk);
        #1;

        // addi r1,#5 ; halt
        clear_prog();
        rom[0] = 9'b010_001_101;
        alu_tbl[0] = 8'd5;
        reset_start();
        build_trace(3);
        run_trace(fw, nr, nw);
        chk("t1_wb_cycle", fw, 4);
        chk("t1_done", done, 1);
        chk("t1_pc", pc, 1);
`ifdef RETIRE_COUNT_EN
        chk("t1_retired", retired, 2);
`else
        chk("t1_retired", retired, 0);
`endif

        // xor ; beq r1,-2 taken -> wraps to 0x3FF (halt there)
        clear_prog();
        rom[0] = 9'b000_010_011;
        rom[1] = 9'b001_001_110;
        alu_tbl[1] = 8'd0;
        reset_start();
        build_trace(2);
        run_trace(fw, nr, nw);
        chk("t2_taken_pc", pc, 10'h3FF);
        // not taken, restarted from HALT without reset
        alu_tbl[1] = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build_trace(2);
        run_trace(fw, nr, nw);
        chk("t2_fall_pc", pc, 2);

        // load (ack after 3 cycles) ; store (same-cycle ack) ; andi ; rls ; halt
        clear_prog();
        rom[0] = 9'b101_011_000; ack_dly[0] = 3;
        rom[1] = 9'b110_100_001; ack_dly[1] = 0;
        rom[2] = 9'b011_101_111;
        rom[3] = 9'b100_110_010;
        reset_start();
        build_trace(2);
        run_trace(fw, nr, nw);
        chk("t3_mem_req_cycles", nr, 5);
        chk("t3_reg_we_cycles", nw, 3);
        chk("t3_first_we_cycle", fw, 8);
`ifdef RETIRE_COUNT_EN
        chk("t3_retired", retired, 5);
`else
        chk("t3_retired", retired, 0);
`endif

        // reset while a load waits in MEM; start asserted in the same cycle
        clear_prog();
        rom[0] = 9'b010_001_001;
        rom[1] = 9'b101_010_000;
        reset_start();
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("t4_in_mem_req", mem_req, 1);
        chk("t4_in_mem_pc", pc, 1);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("t4_rst_mem_req", mem_req, 0);
        chk("t4_rst_pc", pc, 0);
        chk("t4_rst_alu_op", alu_op, 3'b111);
        chk("t4_rst_retired", retired, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t4_idle_alu_op", alu_op, 3'b111);
        chk("t4_idle_pc", pc, 0);
        chk("t4_idle_mem_req", mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 SHALL have parameter RET_W, default 16, retired-instruction counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin execution from pc 0; honoured only in IDLE or HALT.
REQ-006 SHALL have port instr  input  9  instruction word at address pc (combinational ROM).
REQ-007 SHALL have port pc  output  PC_W  current program counter.
REQ-008 SHALL have port alu_op  output  3  ALU instruction code (000 xor, 001 beq, 010 addi, 011 andi, 100 rls, 111 none).
REQ-009 SHALL have port alu_imm_sel  output  1  1 = ALU operand B is alu_imm, 0 = register B.
REQ-010 SHALL have port alu_imm  output  8  zero-extended instr[2:0].
REQ-011 SHALL have port alu_result  input  8  ALU result.
REQ-012 SHALL have ports reg_raddr_a, reg_raddr_b, reg_waddr  output  3 each  register-file addresses.
REQ-013 SHALL have port reg_we  output  1  register write strobe, one cycle.
REQ-014 SHALL have ports mem_req, mem_we  output  1 each  data-memory request and write qualifier.
REQ-015 SHALL have port mem_ack  input  1  data-memory completion.
REQ-016 SHALL have ports done  output  1 (high in HALT) and retired  output  RET_W (instruction count).

Function
REQ-017 SHALL decode instr as op=[8:6], rd=[5:3], rt=[2:0]; opcodes 101 load, 110 store, 111 halt, others as alu_op.
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 SHALL latch instr into an instruction register in FETCH; DECODE drives reg_raddr_a=rd, reg_raddr_b=rt (beq: raddr_b=0).
REQ-020 SHALL hold alu_op from DECODE through WB; alu_op=111 in IDLE, FETCH, HALT.
REQ-021 SHALL set alu_imm_sel=1 for addi, andi, rls; 0 otherwise.
REQ-022 ALU ops (xor/addi/andi/rls): FETCH->DECODE->EXEC->WB, reg_we=1 with reg_waddr=rd in WB only, pc+1; 4 cycles.
REQ-023 beq: EXEC samples alu_result; if zero, pc <= pc + sign-extended rt, else pc+1; no WB; 3 cycles.
REQ-024 pc arithmetic SHALL wrap modulo 2^PC_W in both directions.
REQ-025 load/store: EXEC->MEM; mem_req=1 (mem_we=1 for store) held until mem_ack sampled high, then deasserted next cycle.
REQ-026 load SHALL proceed MEM->WB writing rd; store SHALL proceed MEM->FETCH; mem_ack in the same cycle mem_req first rises SHALL complete.
REQ-027 mem_ack outside MEM SHALL be ignored.
REQ-028 halt: DECODE->HALT; pc unchanged; done=1 until start or reset.
REQ-029 start in HALT or IDLE SHALL set pc=0 and go to FETCH next cycle; start in other states ignored.

Reset
REQ-030 reset SHALL, at the next edge, force IDLE, pc=0, alu_op=111, reg_we=0, mem_req=0, mem_we=0, done=0, retired=0, including mid-MEM (abandons request).
REQ-031 reset SHALL take priority over start.

Configuration
REQ-032 With RETIRE_COUNT_EN defined, retired SHALL increment (wrapping) once per completed instruction, halt included; undefined, retired SHALL be constant 0 and the counter absent.

Structure
REQ-033 cpu_pkg SHALL hold opcode constants (shared with the ALU encoding) and the state enum.
REQ-034 Combinational decode SHALL be a sub-module instr_decode (instr in; alu_op, imm_sel, class flags out).

Verification
REQ-035 reset, start, ROM [addi r1,#5; halt], alu_result 5 -> WB cycle 4 reg_we=1 waddr=1; done=1; pc=1.
REQ-036 beq rt=3'b110 at pc=1, alu_result 0 -> pc=0x3FF (wrap); alu_result 1 -> pc=2.
REQ-037 load with mem_ack delayed 3 cycles -> mem_req high exactly until ack seen, then WB reg_we=1.
REQ-038 reset asserted in MEM -> mem_req=0, pc=0, IDLE next cycle; start ignored that cycle.
REQ-039 RETIRE_COUNT_EN on, 5-instruction program -> retired=5; macro off -> retired=0.
